// File: rtl/conv33_ctrl_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolution window controller.
package conv33_ctrl_pkg;

  localparam int CONV_DIM_WIDTH  = 6;
  localparam int CONV_ADDR_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/conv33_ctrl.sv
// Sequences 3x3 stride-1 windows over a WxH image and counts the results
// coming back from the MAC datapath into a row-major output map.
module conv33_ctrl
  import conv33_ctrl_pkg::*;
#(
  parameter int DIM_WIDTH  = CONV_DIM_WIDTH,
  parameter int ADDR_WIDTH = CONV_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIM_WIDTH-1:0]  cfg_w,
  input  logic [DIM_WIDTH-1:0]  cfg_h,
  input  logic                  stall,
  input  logic                  calc_valid,
  output logic                  conv33_en,
  output logic [DIM_WIDTH-1:0]  win_row,
  output logic [DIM_WIDTH-1:0]  win_col,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err
);

  // Window and write counts need twice the dimension width so 61x61 style maps never truncate.
  localparam int CNT_WIDTH = 2 * DIM_WIDTH;
  localparam logic [DIM_WIDTH-1:0] MIN_DIM = DIM_WIDTH'(3);

  state_e                 state_q, state_d;
  logic [DIM_WIDTH-1:0]   cfgWidth_q, cfgWidth_d;
  logic [DIM_WIDTH-1:0]   cfgHeight_q, cfgHeight_d;
  logic [DIM_WIDTH-1:0]   issueRow_q, issueRow_d;
  logic [DIM_WIDTH-1:0]   issueCol_q, issueCol_d;
  logic                   allIssued_q, allIssued_d;
  logic [CNT_WIDTH-1:0]   wrCount_q, wrCount_d;
  logic [ADDR_WIDTH-1:0]  wrAddr_q, wrAddr_d;
  logic [DIM_WIDTH-1:0]   winRow_q, winRow_d;
  logic [DIM_WIDTH-1:0]   winCol_q, winCol_d;
  logic                   en_q, en_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cfgErr_q, cfgErr_d;

  logic [DIM_WIDTH-1:0]   outW, outH;
  logic [CNT_WIDTH-1:0]   totalWin, wrCountNext;

  assign outW        = cfgWidth_q - DIM_WIDTH'(2);
  assign outH        = cfgHeight_q - DIM_WIDTH'(2);
  assign totalWin    = CNT_WIDTH'(outW) * CNT_WIDTH'(outH);
  assign wr_en       = calc_valid & busy_q;
  assign wrCountNext = wrCount_q + CNT_WIDTH'(wr_en);

  always_comb begin
    state_d     = state_q;
    cfgWidth_d  = cfgWidth_q;
    cfgHeight_d = cfgHeight_q;
    issueRow_d  = issueRow_q;
    issueCol_d  = issueCol_q;
    allIssued_d = allIssued_q;
    wrCount_d   = wrCountNext;
    wrAddr_d    = wr_en ? wrAddr_q + ADDR_WIDTH'(1) : wrAddr_q;
    winRow_d    = winRow_q;
    winCol_d    = winCol_q;
    en_d        = 1'b0;
    cfgErr_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_w >= MIN_DIM && cfg_h >= MIN_DIM) begin
            state_d     = ST_RUN;
            cfgWidth_d  = cfg_w;
            cfgHeight_d = cfg_h;
            issueRow_d  = '0;
            issueCol_d  = '0;
            allIssued_d = 1'b0;
            wrCount_d   = '0;
            wrAddr_d    = '0;
            winRow_d    = '0;
            winCol_d    = '0;
          end else begin
            cfgErr_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        // The last window's enable cycle stays in RUN; DRAIN starts once nothing is left to issue.
        if (allIssued_q) begin
          state_d = ST_DRAIN;
        end else if (!stall) begin
          en_d     = 1'b1;
          winRow_d = issueRow_q;
          winCol_d = issueCol_q;
          if (issueCol_q == outW - DIM_WIDTH'(1)) begin
            issueCol_d = '0;
            if (issueRow_q == outH - DIM_WIDTH'(1)) begin
              allIssued_d = 1'b1;
            end else begin
              issueRow_d = issueRow_q + DIM_WIDTH'(1);
            end
          end else begin
            issueCol_d = issueCol_q + DIM_WIDTH'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (wrCountNext == totalWin) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfgWidth_q  <= '0;
      cfgHeight_q <= '0;
      issueRow_q  <= '0;
      issueCol_q  <= '0;
      allIssued_q <= 1'b0;
      wrCount_q   <= '0;
      wrAddr_q    <= '0;
      winRow_q    <= '0;
      winCol_q    <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfgErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfgWidth_q  <= cfgWidth_d;
      cfgHeight_q <= cfgHeight_d;
      issueRow_q  <= issueRow_d;
      issueCol_q  <= issueCol_d;
      allIssued_q <= allIssued_d;
      wrCount_q   <= wrCount_d;
      wrAddr_q    <= wrAddr_d;
      winRow_q    <= winRow_d;
      winCol_q    <= winCol_d;
      en_q        <= en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfgErr_q    <= cfgErr_d;
    end
  end

  assign conv33_en = en_q;
  assign win_row   = winRow_q;
  assign win_col   = winCol_q;
  assign wr_addr   = wrAddr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_conv33_ctrl.sv
// Self-checking bench for conv33_ctrl: a window-index reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_conv33_ctrl;

  localparam int DW = 6;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_w = '0;
  logic [DW-1:0] cfg_h = '0;
  logic          stall = 1'b0;
  logic          calc_valid = 1'b0;
  logic          conv33_en;
  logic [DW-1:0] win_row, win_col;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy, done, cfg_err;

  conv33_ctrl #(.DIM_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .stall(stall), .calc_valid(calc_valid), .conv33_en(conv33_en),
    .win_row(win_row), .win_col(win_col), .wr_en(wr_en), .wr_addr(wr_addr),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit stallForce = 0, stallRand = 0, calcForce = 0, checkEnable = 0, enSeen = 0;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done; windows are indexed 0..OW*OH-1.
  int mPhase = 0, mW = 0, mH = 0, mIssued = 0, mWrites = 0;
  int expRow = 0, expCol = 0;
  bit expEn = 0, expDone = 0, expErr = 0, expBusy = 0;

  int enCount, wrCount, doneCount, errCount, busySeen, lastRow, lastCol, lastAddr;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int w, input int h);
    cfg_w = DW'(w);
    cfg_h = DW'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clearStats();
    enCount = 0; wrCount = 0; doneCount = 0; errCount = 0; busySeen = 0;
    lastRow = -1; lastCol = -1; lastAddr = -1;
  endtask

  task automatic waitDone(input int budget);
    int n = 0;
    while (doneCount == 0 && n < budget) begin
      tick();
      n++;
    end
    if (doneCount == 0) checkOutput("done_timeout", 0, 1);
    repeat (2) tick();
  endtask

  task automatic waitEnables(input int count, input int budget);
    int n = 0;
    while (enCount < count && n < budget) begin
      tick();
      n++;
    end
    if (enCount < count) checkOutput("enable_timeout", enCount, count);
  endtask

  // Inputs change 1ns after the rising edge; calc_valid echoes last cycle's enable.
  always @(posedge clk) begin
    #1;
    calc_valid = enSeen | calcForce;
    stall = stallForce | (stallRand && ($urandom_range(0, 2) == 0));
  end

  always @(posedge clk) begin
    if (rst) begin
      mPhase = 0; mW = 0; mH = 0; mIssued = 0; mWrites = 0;
      expRow = 0; expCol = 0; expEn = 0; expDone = 0; expErr = 0; expBusy = 0;
    end else begin : modelStep
      bit wrote;
      int ow, oh, total;
      wrote = calc_valid && (mPhase == 1 || mPhase == 2);
      ow = mW - 2;
      oh = mH - 2;
      total = ow * oh;
      expEn = 0; expDone = 0; expErr = 0;
      if (wrote) mWrites++;
      case (mPhase)
        0: if (start) begin
             if (cfg_w >= 3 && cfg_h >= 3) begin
               mPhase = 1; mW = cfg_w; mH = cfg_h; mIssued = 0; mWrites = 0;
               expRow = 0; expCol = 0;
             end else begin
               expErr = 1;
             end
           end
        1: if (mIssued == total) mPhase = 2;
           else if (!stall) begin
             expEn = 1;
             expRow = mIssued / ow;
             expCol = mIssued % ow;
             mIssued++;
           end
        2: if (mWrites == total) begin
             mPhase = 3;
             expDone = 1;
           end
        default: mPhase = 0;
      endcase
      expBusy = (mPhase == 1 || mPhase == 2);
    end
  end

  always @(negedge clk) begin
    enSeen = conv33_en;
    if (checkEnable && !rst) begin
      checkOutput("conv33_en", conv33_en, expEn);
      checkOutput("win_row", win_row, expRow);
      checkOutput("win_col", win_col, expCol);
      checkOutput("wr_en", wr_en, calc_valid && expBusy);
      checkOutput("wr_addr", wr_addr, mWrites % (1 << AW));
      checkOutput("busy", busy, expBusy);
      checkOutput("done", done, expDone);
      checkOutput("cfg_err", cfg_err, expErr);
      if (conv33_en) begin enCount++; lastRow = win_row; lastCol = win_col; end
      if (wr_en) begin wrCount++; lastAddr = wr_addr; end
      if (done) doneCount++;
      if (cfg_err) errCount++;
      if (busy) busySeen++;
    end
  end

  initial begin
    clearStats();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEnable = 1;
    tick();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_wr_addr", wr_addr, 0);

    // 5x5 image, no stall: 9 windows row-major.
    clearStats();
    applyStimulus(5, 5);
    waitDone(200);
    checkOutput("p5_enables", enCount, 9);
    checkOutput("p5_last_row", lastRow, 2);
    checkOutput("p5_last_col", lastCol, 2);
    checkOutput("p5_writes", wrCount, 9);
    checkOutput("p5_last_addr", lastAddr, 8);
    checkOutput("p5_done_count", doneCount, 1);

    // 4x3 image with a stall after the second window.
    clearStats();
    applyStimulus(4, 3);
    waitEnables(2, 50);
    stallForce = 1;
    repeat (3) tick();
    stallForce = 0;
    waitDone(100);
    checkOutput("p43_enables", enCount, 2);
    checkOutput("p43_last_col", lastCol, 1);
    checkOutput("p43_writes", wrCount, 2);
    checkOutput("p43_done_count", doneCount, 1);

    // Too-narrow image is rejected.
    clearStats();
    applyStimulus(2, 8);
    repeat (5) tick();
    checkOutput("bad_cfg_err_count", errCount, 1);
    checkOutput("bad_busy_seen", busySeen, 0);
    checkOutput("bad_enables", enCount, 0);

    // A second start during RUN is ignored.
    clearStats();
    applyStimulus(5, 5);
    repeat (3) tick();
    applyStimulus(6, 6);
    waitDone(200);
    checkOutput("restart_enables", enCount, 9);
    checkOutput("restart_last_row", lastRow, 2);
    checkOutput("restart_last_col", lastCol, 2);
    checkOutput("restart_done_count", doneCount, 1);

    // Mid-pass reset, then a 3x3 pass right after release.
    clearStats();
    applyStimulus(6, 6);
    waitEnables(4, 50);
    rst = 1'b1;
    #1;
    checkOutput("rst_conv33_en", conv33_en, 0);
    checkOutput("rst_win_row", win_row, 0);
    checkOutput("rst_win_col", win_col, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cfg_err", cfg_err, 0);
    tick();
    rst = 1'b0;
    clearStats();
    applyStimulus(3, 3);
    waitDone(50);
    checkOutput("p3_enables", enCount, 1);
    checkOutput("p3_last_row", lastRow, 0);
    checkOutput("p3_last_col", lastCol, 0);
    checkOutput("p3_last_addr", lastAddr, 0);
    checkOutput("p3_done_count", doneCount, 1);

    // Stray calc_valid while idle must not write.
    clearStats();
    calcForce = 1;
    repeat (3) tick();
    calcForce = 0;
    repeat (2) tick();
    checkOutput("idle_writes", wrCount, 0);
    checkOutput("idle_wr_addr", wr_addr, 1);

    // Random geometry with random stall.
    stallRand = 1;
    for (int i = 0; i < 8; i++) begin
      int w, h;
      w = $urandom_range(1, 14);
      h = $urandom_range(1, 14);
      clearStats();
      applyStimulus(w, h);
      if (w >= 3 && h >= 3) begin
        waitDone(2000);
        checkOutput("rand_enables", enCount, (w - 2) * (h - 2));
        checkOutput("rand_writes", wrCount, (w - 2) * (h - 2));
      end else begin
        repeat (3) tick();
        checkOutput("rand_cfg_err", errCount, 1);
      end
    end
    stallRand = 0;
    repeat (2) tick();

    // Largest image.
    clearStats();
    applyStimulus(63, 63);
    waitDone(5000);
    checkOutput("p63_enables", enCount, 3721);
    checkOutput("p63_last_row", lastRow, 60);
    checkOutput("p63_last_col", lastCol, 60);
    checkOutput("p63_last_addr", lastAddr, 3720);
    checkOutput("p63_done_count", doneCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
